// File: rtl/sim_run_ctrl_if.sv
// Purpose : run-control bundle between sim_run_ctrl and the DUT/harness it sequences.
// Latency : n/a (wires only); all controller-driven members are registered at the source.
// Backpressure: none; dut_finish/dut_fail are levels sampled every clock, no handshake.
// Ports   : master = controller (samples dut_finish/dut_fail, drives dut_reset, cycle,
//           dump_en, done, pass, timeout); slave = DUT/harness side (the mirror image).
interface sim_run_ctrl_if;
    logic        dut_finish;
    logic        dut_fail;
    logic        dut_reset;
    logic [63:0] cycle;
    logic        dump_en;
    logic        done;
    logic        pass;
    logic        timeout;

    modport master (
        input  dut_finish,
        input  dut_fail,
        output dut_reset,
        output cycle,
        output dump_en,
        output done,
        output pass,
        output timeout
    );

    modport slave (
        output dut_finish,
        output dut_fail,
        input  dut_reset,
        input  cycle,
        input  dump_en,
        input  done,
        input  pass,
        input  timeout
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// Purpose : simulation run sequencer: holds the DUT in reset, counts run cycles, gates the
//           waveform-dump window and latches the final done/pass/timeout verdict.
// Latency : every output is a flop; input levels act on the next rising edge.
// Backpressure: none; dut_finish/dut_fail are level inputs, ignored in HOLD and DONE.
// Ports   : i_clk, i_rst_n (async active-low); run (sim_run_ctrl_if.master) carrying
//           dut_finish/dut_fail in and dut_reset, cycle[63:0], dump_en, done, pass, timeout out.
module sim_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 5,
    parameter logic [63:0] MAX_CYCLES   = 64'd1000000,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [63:0] DUMP_START   = 64'd0,
    parameter logic [63:0] DUMP_END     = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    sim_run_ctrl_if.master run
);

    localparam logic [1:0] S_HOLD  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] HOLD_LAST  = 16'(RESET_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [63:0] MAX_LAST   = MAX_CYCLES - 64'd1;
    localparam logic        TIMEOUT_EN = (MAX_CYCLES != 64'd0);
    localparam logic        NO_DRAIN   = (DRAIN_CYCLES == 0);

    // Reset-release synchroniser; HOLD only starts counting once r_sync[1] is set.
    logic [1:0]  r_sync;
    logic [1:0]  r_state;
    logic [15:0] r_hold_cnt;
    logic [31:0] r_drain_cnt;
    logic        r_fail_seen;
    logic        r_fin_seen;
    logic        r_dut_reset;
    logic [63:0] r_cycle;
    logic        r_dump_en;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_hold_nxt;
    logic [31:0] w_drain_nxt;
    logic        w_fail_nxt;
    logic        w_fin_nxt;
    logic        w_dut_reset_nxt;
    logic [63:0] w_cycle_nxt;
    logic        w_dump_nxt;
    logic        w_done_nxt;
    logic        w_pass_nxt;
    logic        w_timeout_nxt;
    logic        w_counting;
    logic        w_active_nxt;

    // Compared as non-negative signed values so a zero window bound is not a
    // constant-folded unsigned comparison.
    function automatic logic in_window(input logic [63:0] c);
        return ($signed({1'b0, c}) >= $signed({1'b0, DUMP_START})) &&
               ($signed({1'b0, c}) <  $signed({1'b0, DUMP_END}));
    endfunction

    // The cycle counter advances on every edge taken from RUN or DRAIN, including
    // the edge that leaves for DONE, so the frozen value is one past the last
    // cycle at which a decision was made.
    assign w_counting  = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_cycle_nxt = w_counting ? (r_cycle + 64'd1) : r_cycle;

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_nxt      = r_hold_cnt;
        w_drain_nxt     = r_drain_cnt;
        w_fail_nxt      = r_fail_seen;
        w_fin_nxt       = r_fin_seen;
        w_dut_reset_nxt = r_dut_reset;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_timeout_nxt   = r_timeout;

        case (r_state)
            S_HOLD: begin
                if (r_sync[1]) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt     = S_RUN;
                        w_dut_reset_nxt = 1'b0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 16'd1;
                    end
                end
            end
            S_RUN: begin
                // fail outranks finish, both outrank the timeout
                if (run.dut_fail || run.dut_finish) begin
                    w_fail_nxt = run.dut_fail;
                    w_fin_nxt  = run.dut_finish;
                    if (NO_DRAIN) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = run.dut_finish && !run.dut_fail;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = 32'd0;
                    end
                end else if (TIMEOUT_EN && (r_cycle == MAX_LAST)) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_pass_nxt    = 1'b0;
                end
            end
            S_DRAIN: begin
                // a late failure still vetoes the pass; a late finish means nothing
                w_fail_nxt = r_fail_seen || run.dut_fail;
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = r_fin_seen && !w_fail_nxt;
                end else begin
                    w_drain_nxt = r_drain_cnt + 32'd1;
                end
            end
            default: begin
                // DONE is terminal until the controller reset
                w_state_nxt = S_DONE;
            end
        endcase
    end

    // dump_en is computed from the next state/cycle so the registered flag lines
    // up with the registered cycle value it describes.
    assign w_active_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    assign w_dump_nxt   = w_active_nxt && in_window(w_cycle_nxt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync      <= 2'b00;
            r_state     <= S_HOLD;
            r_hold_cnt  <= 16'd0;
            r_drain_cnt <= 32'd0;
            r_fail_seen <= 1'b0;
            r_fin_seen  <= 1'b0;
            r_dut_reset <= 1'b1;
            r_cycle     <= 64'd0;
            r_dump_en   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], 1'b1};
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_fail_seen <= w_fail_nxt;
            r_fin_seen  <= w_fin_nxt;
            r_dut_reset <= w_dut_reset_nxt;
            r_cycle     <= w_cycle_nxt;
            r_dump_en   <= w_dump_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign run.dut_reset = r_dut_reset;
    assign run.cycle     = r_cycle;
    assign run.dump_en   = r_dump_en;
    assign run.done      = r_done;
    assign run.pass      = r_pass;
    assign run.timeout   = r_timeout;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Purpose : exercises four sim_run_ctrl configurations side by side against a run-level model.
// Latency : model outputs are compared on every falling edge, after the rising edge they follow.
// Backpressure: none; finish/fail levels are driven from a per-run event plan plus random noise.
module tb_sim_run_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic drv_fin  [4];
    logic drv_fail [4];

    sim_run_ctrl_if if_a ();
    sim_run_ctrl_if if_b ();
    sim_run_ctrl_if if_c ();
    sim_run_ctrl_if if_d ();

    // A: all defaults.  B: 20-cycle timeout.  C: short hold, no timeout, 2-cycle drain,
    // dump window [3,6).  D: no drain, 12-cycle timeout, empty dump window.
    sim_run_ctrl u_a (.i_clk(clk), .i_rst_n(rst_n), .run(if_a));
    sim_run_ctrl #(.MAX_CYCLES(64'd20)) u_b (.i_clk(clk), .i_rst_n(rst_n), .run(if_b));
    sim_run_ctrl #(.RESET_CYCLES(1), .MAX_CYCLES(64'd0), .DRAIN_CYCLES(2),
                   .DUMP_START(64'd3), .DUMP_END(64'd6))
        u_c (.i_clk(clk), .i_rst_n(rst_n), .run(if_c));
    sim_run_ctrl #(.RESET_CYCLES(3), .MAX_CYCLES(64'd12), .DRAIN_CYCLES(0),
                   .DUMP_START(64'd5), .DUMP_END(64'd5))
        u_d (.i_clk(clk), .i_rst_n(rst_n), .run(if_d));

    assign if_a.dut_finish = drv_fin[0];  assign if_a.dut_fail = drv_fail[0];
    assign if_b.dut_finish = drv_fin[1];  assign if_b.dut_fail = drv_fail[1];
    assign if_c.dut_finish = drv_fin[2];  assign if_c.dut_fail = drv_fail[2];
    assign if_d.dut_finish = drv_fin[3];  assign if_d.dut_fail = drv_fail[3];

    logic [3:0]  o_rst, o_dump, o_done, o_pass, o_to;
    logic [63:0] o_cyc [4];
    assign o_rst[0] = if_a.dut_reset; assign o_dump[0] = if_a.dump_en; assign o_done[0] = if_a.done;
    assign o_pass[0] = if_a.pass;     assign o_to[0] = if_a.timeout;   assign o_cyc[0] = if_a.cycle;
    assign o_rst[1] = if_b.dut_reset; assign o_dump[1] = if_b.dump_en; assign o_done[1] = if_b.done;
    assign o_pass[1] = if_b.pass;     assign o_to[1] = if_b.timeout;   assign o_cyc[1] = if_b.cycle;
    assign o_rst[2] = if_c.dut_reset; assign o_dump[2] = if_c.dump_en; assign o_done[2] = if_c.done;
    assign o_pass[2] = if_c.pass;     assign o_to[2] = if_c.timeout;   assign o_cyc[2] = if_c.cycle;
    assign o_rst[3] = if_d.dut_reset; assign o_dump[3] = if_d.dump_en; assign o_done[3] = if_d.done;
    assign o_pass[3] = if_d.pass;     assign o_to[3] = if_d.timeout;   assign o_cyc[3] = if_d.cycle;

    // ---------------- per-instance configuration ----------------
    function automatic int p_rc(input int i);
        case (i)
            2:       return 1;
            3:       return 3;
            default: return 5;
        endcase
    endfunction
    function automatic longint unsigned p_max(input int i);
        case (i)
            0:       return 64'd1000000;
            1:       return 64'd20;
            2:       return 64'd0;
            default: return 64'd12;
        endcase
    endfunction
    function automatic int p_dc(input int i);
        case (i)
            2:       return 2;
            3:       return 0;
            default: return 4;
        endcase
    endfunction
    function automatic longint unsigned p_ds(input int i);
        case (i)
            2:       return 64'd3;
            3:       return 64'd5;
            default: return 64'd0;
        endcase
    endfunction
    function automatic longint unsigned p_de(input int i);
        case (i)
            2:       return 64'd6;
            3:       return 64'd5;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // ---------------- run-level model ----------------
    // Rising edges since release: two synchroniser edges, then RESET_CYCLES counted
    // edges, the last of which releases the DUT. After that every edge adds one run
    // cycle until the verdict is reached.
    int              m_edges   [4];
    bit              m_live    [4];   // DUT released from reset
    bit              m_ended   [4];   // finish/fail event taken, draining
    int              m_left    [4];   // drain edges still to go
    bit              m_done    [4];
    bit              m_pass    [4];
    bit              m_to      [4];
    bit              m_fin     [4];
    bit              m_failseen[4];
    longint unsigned m_cyc     [4];

    always @(posedge clk) begin
        bit fa, fi;
        for (int i = 0; i < 4; i++) begin
            fa = drv_fail[i];
            fi = drv_fin[i];
            if (!rst_n) begin
                m_edges[i] = 0;  m_live[i] = 0; m_ended[i] = 0; m_left[i] = 0;
                m_done[i]  = 0;  m_pass[i] = 0; m_to[i]    = 0; m_fin[i]  = 0;
                m_failseen[i] = 0; m_cyc[i] = 0;
            end else if (!m_live[i]) begin
                m_edges[i]++;
                if (m_edges[i] == 2 + p_rc(i)) m_live[i] = 1;
            end else if (!m_done[i]) begin
                if (!m_ended[i]) begin
                    if (fa || fi) begin
                        m_ended[i] = 1; m_failseen[i] = fa; m_fin[i] = fi; m_left[i] = p_dc(i);
                    end else if (p_max(i) != 0 && m_cyc[i] == p_max(i) - 1) begin
                        m_done[i] = 1; m_to[i] = 1;
                    end
                end else begin
                    if (fa) m_failseen[i] = 1;
                    m_left[i]--;
                end
                if (m_ended[i] && m_left[i] == 0) begin
                    m_done[i] = 1;
                    m_pass[i] = m_fin[i] && !m_failseen[i];
                end
                m_cyc[i]++;
            end
        end
    end

    // ---------------- checking ----------------
    int              n_chk = 0;
    int              n_pass = 0;
    int              hi_a = 0;            // samples with A still in reset since release
    logic [63:0]     dump_mask_c = '0;    // cycle values at which C had dump_en high
    bit              dump_seen_d = 0;

    longint unsigned ev_cyc  [4];
    int              ev_kind [4];         // 0 none, 1 finish, 2 fail, 3 both
    int              dr_fail [4];         // fail during drain: 0 never, 1 always, 2 random

    task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            logic e_dump;
            e_dump = m_live[i] && !m_done[i] && (m_cyc[i] >= p_ds(i)) && (m_cyc[i] < p_de(i));
            n_chk++;
            if (o_rst[i] === !m_live[i] && o_cyc[i] === m_cyc[i] && o_dump[i] === e_dump &&
                o_done[i] === m_done[i] && o_pass[i] === m_pass[i] && o_to[i] === m_to[i])
                n_pass++;
            else
                $display("FAIL model_cmp inst=%0d t=%0t got rst=%b cyc=%0d dump=%b done=%b pass=%b to=%b expected rst=%b cyc=%0d dump=%b done=%b pass=%b to=%b",
                         i, $time, o_rst[i], o_cyc[i], o_dump[i], o_done[i], o_pass[i], o_to[i],
                         !m_live[i], m_cyc[i], e_dump, m_done[i], m_pass[i], m_to[i]);
        end
        if (rst_n && o_rst[0]) hi_a++;
        if (o_dump[2] === 1'b1 && o_cyc[2] < 64) dump_mask_c = dump_mask_c | (64'd1 << o_cyc[2][5:0]);
        if (o_dump[3] === 1'b1) dump_seen_d = 1;
    endtask

    task automatic drive_all();
        for (int i = 0; i < 4; i++) begin
            if (!m_live[i] || m_done[i]) begin
                // HOLD/DONE: inputs must be ignored, so throw noise at them
                drv_fin[i]  = 1'($urandom_range(0, 1));
                drv_fail[i] = 1'($urandom_range(0, 1));
            end else if (!m_ended[i]) begin
                drv_fin[i]  = (m_cyc[i] == ev_cyc[i]) && (ev_kind[i] == 1 || ev_kind[i] == 3);
                drv_fail[i] = (m_cyc[i] == ev_cyc[i]) && (ev_kind[i] >= 2);
            end else begin
                drv_fin[i]  = 1'($urandom_range(0, 1));
                drv_fail[i] = (dr_fail[i] == 1) || (dr_fail[i] == 2 && $urandom_range(0, 3) == 0);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        #1 drive_all();
    endtask

    task automatic do_reset(input int hold_edges);
        @(negedge clk);
        compare_all();
        #1 rst_n = 1'b0;
        #1;
        // asynchronous: outputs must already be back at reset values
        for (int i = 0; i < 4; i++) begin
            chk64("async_reset_dut_reset", 64'(o_rst[i]), 64'd1);
            chk64("async_reset_flags", {60'd0, o_done[i], o_pass[i], o_to[i], o_dump[i]}, 64'd0);
            chk64("async_reset_cycle", o_cyc[i], 64'd0);
        end
        repeat (hold_edges) begin
            @(negedge clk);
            compare_all();
        end
        #1 rst_n = 1'b1;
        hi_a = 0;
    endtask

    task automatic set_plan(input int i, input longint unsigned c, input int k, input int d);
        ev_cyc[i] = c; ev_kind[i] = k; dr_fail[i] = d;
    endtask

    // pulse_mode: 0 none, 1 reset once A is draining, 2 reset at a random cycle
    task automatic run_case(input int pulse_mode);
        int budget;
        int pulse_at;
        bit pulsed;
        dump_mask_c = '0;
        dump_seen_d = 0;
        do_reset(2);
        budget   = 0;
        pulsed   = 0;
        pulse_at = int'($urandom_range(1, 40));
        while (o_done !== 4'hF && budget < 300) begin
            step();
            budget++;
            if (!pulsed && ((pulse_mode == 1 && m_ended[0] && !m_done[0]) ||
                            (pulse_mode == 2 && budget == pulse_at))) begin
                do_reset(2);
                pulsed = 1;
            end
        end
        n_chk++;
        if (o_done === 4'hF) n_pass++;
        else $display("FAIL run_budget got done=%b expected done=1111 within 300 cycles", o_done);
        step();   // one more cycle to confirm DONE outputs stay frozen
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            drv_fin[i] = 1'b0; drv_fail[i] = 1'b0;
        end

        // Run 1: A finish@10; B no events (timeout); C fail+finish@7; D finish@3.
        set_plan(0, 64'd10, 1, 0);
        set_plan(1, 64'd0,  0, 0);
        set_plan(2, 64'd7,  3, 0);
        set_plan(3, 64'd3,  1, 0);
        run_case(0);
        // A seen in reset after 2 sync edges + 4 counting edges; the 5th counted edge drops it
        chk64("A_reset_samples", 64'(hi_a), 64'd6);
        chk64("A_cycle_frozen", o_cyc[0], 64'd15);
        chk64("A_pass_to", {62'd0, o_pass[0], o_to[0]}, 64'd2);
        chk64("B_timeout_cycle", o_cyc[1], 64'd20);
        chk64("B_pass_to", {62'd0, o_pass[1], o_to[1]}, 64'd1);
        chk64("C_both_pass_to", {62'd0, o_pass[2], o_to[2]}, 64'd0);
        chk64("C_cycle_after_drain", o_cyc[2], 64'd10);
        chk64("C_dump_cycles", dump_mask_c, 64'h38);
        chk64("D_nodrain_cycle", o_cyc[3], 64'd4);
        chk64("D_dump_never", 64'(dump_seen_d), 64'd0);

        // Run 2: finish exactly at MAX-1 on B; fail during C's drain; A fails; D times out.
        set_plan(0, 64'd3,  2, 0);
        set_plan(1, 64'd19, 1, 0);
        set_plan(2, 64'd2,  1, 1);
        set_plan(3, 64'd0,  0, 0);
        run_case(0);
        chk64("B_finish_beats_timeout", {62'd0, o_pass[1], o_to[1]}, 64'd2);
        chk64("B_cycle", o_cyc[1], 64'd24);
        chk64("C_drain_fail_pass", 64'(o_pass[2]), 64'd0);
        chk64("A_fail_cycle", o_cyc[0], 64'd8);
        chk64("D_timeout_cycle", {o_cyc[3][61:0], o_to[3], o_pass[3]}, {62'd12, 2'b10});

        // Run 3: reset pulsed while A drains, then a full clean rerun.
        set_plan(0, 64'd4, 1, 0);
        set_plan(1, 64'd5, 1, 0);
        set_plan(2, 64'd1, 1, 0);
        set_plan(3, 64'd2, 1, 0);
        run_case(1);
        chk64("rerun_all_pass", {60'd0, o_pass}, 64'hF);
        chk64("rerun_A_cycle", o_cyc[0], 64'd9);

        // Randomised runs, some with a reset at an arbitrary point.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (i == 0 || i == 2) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
                set_plan(i, 64'($urandom_range(0, 24)), k, int'($urandom_range(0, 2)));
            end
            run_case(($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 5: number of clock cycles dut_reset is held after controller reset release; legal range 1..65535.
REQ-002 Parameter MAX_CYCLES, default 1000000: run-phase cycle limit before timeout; 0 disables timeout.
REQ-003 Parameter DRAIN_CYCLES, default 4: cycles spent in DRAIN after finish/fail before DONE; 0 goes directly to DONE.
REQ-004 Parameter DUMP_START, default 0: first cycle value with dump_en high.
REQ-005 Parameter DUMP_END, default 2^64-1: first cycle value with dump_en low again; DUMP_END <= DUMP_START means dump never enabled.
REQ-006 clock  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low controller reset.
REQ-008 dut_finish  input  1  DUT reports test complete (pass), level, sampled on clock.
REQ-009 dut_fail  input  1  DUT reports failure, level, sampled on clock.
REQ-010 dut_reset  output  1  active-high reset driven to the DUT.
REQ-011 cycle  output  64  run-cycle count since dut_reset deasserted.
REQ-012 dump_en  output  1  waveform-dump window enable.
REQ-013 done  output  1  run finished, sticky.
REQ-014 pass  output  1  run finished via dut_finish without fail or timeout, sticky.
REQ-015 timeout  output  1  run finished by MAX_CYCLES limit, sticky.

Function
REQ-016 States HOLD, RUN, DRAIN, DONE; all outputs registered.
REQ-017 HOLD: dut_reset=1, hold counter increments each cycle; after RESET_CYCLES cycles in HOLD go to RUN and dut_reset=0 on the same edge.
REQ-018 RUN/DRAIN: cycle increments by 1 every clock; cycle holds in HOLD and DONE; 64-bit wrap to 0 without flagging.
REQ-019 RUN: dut_fail=1 -> DRAIN with fail latched; else dut_finish=1 -> DRAIN with pass candidate latched.
REQ-020 RUN: MAX_CYCLES!=0 and cycle==MAX_CYCLES-1 with neither input high -> DONE, timeout=1, pass=0 (no drain).
REQ-021 Simultaneous events, priority: dut_fail > dut_finish > timeout.
REQ-022 DRAIN: counts DRAIN_CYCLES cycles then DONE; dut_fail seen during DRAIN clears the pass candidate; dut_finish ignored.
REQ-023 Entering DONE: done=1; pass=1 only if finish latched and no fail seen; state remains DONE until reset.
REQ-024 dump_en=1 iff state is RUN or DRAIN and DUMP_START <= cycle < DUMP_END, evaluated on the cycle value of the same clock.
REQ-025 dut_fail/dut_finish ignored in HOLD and DONE.

Reset
REQ-026 reset low asynchronously forces HOLD, dut_reset=1, cycle=0, hold counter=0, dump_en=0, done=0, pass=0, timeout=0.
REQ-027 reset asserted mid-RUN/DRAIN/DONE behaves identically to power-on; HOLD restarts full RESET_CYCLES count after release.
REQ-028 Release of reset is synchronized internally (two-flop) before leaving HOLD counting; dut_reset stays 1 during synchronization.

Verification
REQ-029 Defaults, release reset at t0, dut_finish=1 at cycle=10 -> dut_reset low after 5 counted cycles, DRAIN 4 cycles, done=1, pass=1, timeout=0, cycle frozen at 15.
REQ-030 MAX_CYCLES=20, no inputs -> done=1, timeout=1, pass=0 at cycle=19, no DRAIN.
REQ-031 dut_fail and dut_finish both high at cycle=7 -> DRAIN, done=1, pass=0, timeout=0.
REQ-032 MAX_CYCLES=20, dut_finish=1 at cycle=19 -> finish wins, pass=1, timeout=0.
REQ-033 DUMP_START=3, DUMP_END=6 -> dump_en high exactly for cycle values 3,4,5; low in HOLD and DONE.
REQ-034 reset pulsed low during DRAIN -> immediate dut_reset=1, all flags 0, full rerun completes with pass=1.
